// File: rtl/timer_mmio.sv
// Memory-mapped 32-bit timer: prescaler, compare/match with optional auto-reload, W1C status, IRQ.
// Optional input-capture channel is built when TIMER_MMIO_CAPTURE_EN is defined.
module timer_mmio #(
    parameter logic [4:0] pBASE = 5'b11110
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iTMR_CE,
    input  logic        iTMR_RD,
    input  logic        iTMR_WR,
    input  logic [7:0]  iTMR_ADDR,
    input  logic [31:0] iTMR_DATA,
    output logic [31:0] oTMR_DATA,
    output logic        oTMR_SEL,
    output logic        oTMR_IRQ
`ifdef TIMER_MMIO_CAPTURE_EN
    ,
    input  logic        iCAP
`endif
);

    logic        hit;
    logic [2:0]  offset;
    logic        wr_en;
    logic        rd_en;

    logic        en;
    logic        auto_reload;
    logic        irq_en;
    logic [7:0]  prescale;
    logic [7:0]  presc_cnt;
    logic [31:0] count;
    logic [31:0] compare;
    logic        match;
    logic        capf;
    logic [31:0] capture;
    logic [31:0] rd_data;

    logic        cnt_wr;
    logic        st_wr;
    logic        tick;
    logic        match_set;

    assign hit    = iTMR_CE && (iTMR_ADDR[7:3] == pBASE);
    assign offset = iTMR_ADDR[2:0];
    assign wr_en  = hit && iTMR_WR;
    assign rd_en  = hit && iTMR_RD;

    assign cnt_wr    = wr_en && (offset == 3'd1);
    assign st_wr     = wr_en && (offset == 3'd3);
    // A bus write to COUNT swallows the tick entirely, including its match.
    assign tick      = en && (presc_cnt == prescale) && !cnt_wr;
    assign match_set = tick && (count == compare);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= 8'd0;
            presc_cnt   <= 8'd0;
            count       <= 32'd0;
            compare     <= 32'hFFFF_FFFF;
            match       <= 1'b0;
        end else begin
            if (wr_en && (offset == 3'd0)) begin
                en          <= iTMR_DATA[0];
                auto_reload <= iTMR_DATA[1];
                irq_en      <= iTMR_DATA[2];
                prescale    <= iTMR_DATA[15:8];
            end
            if (wr_en && (offset == 3'd2)) begin
                compare <= iTMR_DATA;
            end
            if (cnt_wr) begin
                count     <= iTMR_DATA;
                presc_cnt <= 8'd0;
            end else if (en) begin
                if (tick) begin
                    presc_cnt <= 8'd0;
                    count     <= (match_set && auto_reload) ? 32'd0 : count + 32'd1;
                end else begin
                    presc_cnt <= presc_cnt + 8'd1;
                end
            end
            // Hardware set outranks a same-cycle write-1-to-clear.
            match <= match_set || (match && !(st_wr && iTMR_DATA[0]));
        end
    end

`ifdef TIMER_MMIO_CAPTURE_EN
    logic cap_s1;
    logic cap_s2;
    logic cap_d;
    logic cap_rise;

    assign cap_rise = cap_s2 && !cap_d;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cap_s1  <= 1'b0;
            cap_s2  <= 1'b0;
            cap_d   <= 1'b0;
            capture <= 32'd0;
            capf    <= 1'b0;
        end else begin
            cap_s1 <= iCAP;
            cap_s2 <= cap_s1;
            cap_d  <= cap_s2;
            if (cap_rise) begin
                capture <= count;
            end
            capf <= cap_rise || (capf && !(st_wr && iTMR_DATA[1]));
        end
    end
`else
    assign capf    = 1'b0;
    assign capture = 32'd0;
`endif

    // NOTE: rd_data gets a default before the case so no latch is inferred for unmapped offsets.
    always_comb begin
        rd_data = 32'd0;
        case (offset)
            3'd0:    rd_data = {16'd0, prescale, 5'd0, irq_en, auto_reload, en};
            3'd1:    rd_data = count;
            3'd2:    rd_data = compare;
            3'd3:    rd_data = {30'd0, capf, match};
            3'd4:    rd_data = capture;
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oTMR_DATA <= 32'd0;
            oTMR_SEL  <= 1'b0;
        end else begin
            oTMR_DATA <= rd_en ? rd_data : 32'd0;
            oTMR_SEL  <= rd_en;
        end
    end

    assign oTMR_IRQ = match && irq_en;

endmodule

// File: tb/tb_timer_mmio.sv
// Self-checking bench for timer_mmio: cycle model compared every cycle plus directed literal checks.
// Capture scenarios run only when TIMER_MMIO_CAPTURE_EN is defined.
`timescale 1ns/1ps
module tb_timer_mmio;

    localparam logic [4:0] BASE = 5'b11110;
`ifdef TIMER_MMIO_CAPTURE_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        ce = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  addr = 8'd0;
    logic [31:0] wdata = 32'd0;
    logic        cap_sig = 1'b0;
    logic [31:0] oTMR_DATA;
    logic        oTMR_SEL;
    logic        oTMR_IRQ;

    int checks = 0;
    int failures = 0;

    always #5 iCLK = ~iCLK;

    timer_mmio #(.pBASE(BASE)) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iTMR_CE   (ce),
        .iTMR_RD   (rd),
        .iTMR_WR   (wr),
        .iTMR_ADDR (addr),
        .iTMR_DATA (wdata),
        .oTMR_DATA (oTMR_DATA),
        .oTMR_SEL  (oTMR_SEL),
        .oTMR_IRQ  (oTMR_IRQ)
`ifdef TIMER_MMIO_CAPTURE_EN
        ,
        .iCAP      (cap_sig)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Register-level view of the timer, advanced once per rising edge.
    typedef struct packed {
        bit        en, ar, ie;
        bit [7:0]  ps, phase;
        bit [31:0] cnt, cmp, cap;
        bit        match, capf;
        bit [31:0] rdata;
        bit        sel;
    } model_t;

    function automatic model_t model_reset();
        model_t n;
        n     = '0;
        n.cmp = 32'hFFFF_FFFF;
        return n;
    endfunction

    function automatic bit [31:0] reg_value(model_t s, bit [2:0] off);
        case (off)
            3'd0:    return {16'd0, s.ps, 5'd0, s.ie, s.ar, s.en};
            3'd1:    return s.cnt;
            3'd2:    return s.cmp;
            3'd3:    return {30'd0, s.capf, s.match};
            3'd4:    return CAP_EN ? s.cap : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic model_t model_next(model_t s, bit rst, bit c, bit r, bit w,
                                          bit [7:0] a, bit [31:0] d, bit cap_rise);
        model_t    n;
        bit        hit, cnt_wr, ticked, set_m, set_c;
        bit [2:0]  off;
        if (rst) return model_reset();
        n      = s;
        hit    = c && (a[7:3] == BASE);
        off    = a[2:0];
        n.sel  = hit && r;
        n.rdata = n.sel ? reg_value(s, off) : 32'd0;
        cnt_wr = hit && w && off == 3'd1;
        ticked = s.en && s.phase == s.ps && !cnt_wr;
        set_m  = ticked && s.cnt == s.cmp;
        set_c  = CAP_EN && cap_rise;
        if (cnt_wr) begin
            n.cnt   = d;
            n.phase = 8'd0;
        end else if (s.en) begin
            n.phase = ticked ? 8'd0 : s.phase + 8'd1;
            if (ticked) n.cnt = (set_m && s.ar) ? 32'd0 : s.cnt + 32'd1;
        end
        if (set_c) n.cap = s.cnt;
        if (hit && w && off == 3'd0) begin
            n.en = d[0];
            n.ar = d[1];
            n.ie = d[2];
            n.ps = d[15:8];
        end
        if (hit && w && off == 3'd2) n.cmp = d;
        n.match = set_m || (s.match && !(hit && w && off == 3'd3 && d[0]));
        n.capf  = set_c || (s.capf && !(hit && w && off == 3'd3 && d[1]));
        return n;
    endfunction

    model_t   m;
    bit       model_valid = 1'b0;
    bit [2:0] cap_hist = 3'b0;

    always @(posedge iCLK) begin
        m <= model_next(m, iRST, ce, rd, wr, addr, wdata, cap_hist[1] && !cap_hist[2]);
        cap_hist <= iRST ? 3'b0 : {cap_hist[1:0], cap_sig};
        if (iRST) model_valid <= 1'b1;
    end

    always @(negedge iCLK) begin
        if (model_valid) begin
            check("cyc_rdata", oTMR_DATA, m.rdata);
            check("cyc_sel", {31'd0, oTMR_SEL}, {31'd0, m.sel});
            check("cyc_irq", {31'd0, oTMR_IRQ}, {31'd0, m.match && m.ie});
        end
    end

    // Bus helpers: start and end on a falling edge; the access happens on the rising edge between.
    task automatic access(input bit c, input bit r, input bit w, input logic [7:0] a,
                          input logic [31:0] d, output logic [31:0] q, output logic s);
        ce = c; rd = r; wr = w; addr = a; wdata = d;
        @(negedge iCLK);
        ce = 1'b0; rd = 1'b0; wr = 1'b0;
        q = oTMR_DATA;
        s = oTMR_SEL;
    endtask

    task automatic wr_reg(input logic [2:0] off, input logic [31:0] d);
        logic [31:0] q;
        logic        s;
        access(1'b1, 1'b0, 1'b1, {BASE, off}, d, q, s);
    endtask

    task automatic check_read(input string name, input logic [2:0] off, input logic [31:0] exp);
        logic [31:0] q;
        logic        s;
        access(1'b1, 1'b1, 1'b0, {BASE, off}, 32'd0, q, s);
        check(name, q, exp);
        check({name, "_sel"}, {31'd0, s}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] q;
        logic        s;

        iRST = 1'b1;
        idle(2);
        iRST = 1'b0;
        check_read("rst_ctrl", 3'd0, 32'h0);
        check_read("rst_count", 3'd1, 32'h0);
        check_read("rst_compare", 3'd2, 32'hFFFF_FFFF);
        check_read("rst_status", 3'd3, 32'h0);

        // Prescale 3: COUNT advances every 4 cycles.
        wr_reg(3'd0, 32'h0000_0301);
        idle(40);
        check_read("presc_count", 3'd1, 32'd10);
        wr_reg(3'd0, 32'h0);

        // Auto-reload at COMPARE=5 with IRQ enabled.
        wr_reg(3'd1, 32'h0);
        wr_reg(3'd2, 32'd5);
        wr_reg(3'd0, 32'h0000_0007);
        idle(5);
        check("ar_irq_low", {31'd0, oTMR_IRQ}, 32'd0);
        check_read("ar_count5", 3'd1, 32'd5);
        check("ar_irq_high", {31'd0, oTMR_IRQ}, 32'd1);
        check_read("ar_count0", 3'd1, 32'd0);
        check_read("ar_status", 3'd3, 32'd1);
        wr_reg(3'd3, 32'd1);
        check("ar_irq_cleared", {31'd0, oTMR_IRQ}, 32'd0);
        wr_reg(3'd0, 32'h0);

        // Wrap through 0xFFFFFFFF with a far-away compare.
        wr_reg(3'd2, 32'h10);
        wr_reg(3'd1, 32'hFFFF_FFFE);
        wr_reg(3'd0, 32'h1);
        check_read("wrap_fffe", 3'd1, 32'hFFFF_FFFE);
        check_read("wrap_ffff", 3'd1, 32'hFFFF_FFFF);
        check_read("wrap_zero", 3'd1, 32'h0);
        check_read("wrap_nomatch", 3'd3, 32'h0);
        wr_reg(3'd0, 32'h0);

        // Decode: misses, CE low, and read-only CAPTURE.
        wr_reg(3'd1, 32'h1234);
        wr_reg(3'd2, 32'hABCD);
        wr_reg(3'd0, 32'h0500);
        access(1'b1, 1'b0, 1'b1, 8'h00, 32'hFFFF_FFFF, q, s);
        access(1'b1, 1'b0, 1'b1, 8'hEF, 32'hFFFF_FFFF, q, s);
        access(1'b0, 1'b0, 1'b1, 8'hF1, 32'hFFFF_FFFF, q, s);
        wr_reg(3'd4, 32'hFFFF_FFFF);
        access(1'b1, 1'b1, 1'b0, 8'hEF, 32'h0, q, s);
        check("dec_ef_data", q, 32'h0);
        check("dec_ef_sel", {31'd0, s}, 32'd0);
        access(1'b1, 1'b1, 1'b0, 8'hF5, 32'h0, q, s);
        check("dec_f5_data", q, 32'h0);
        check("dec_f5_sel", {31'd0, s}, 32'd1);
        check_read("dec_ctrl", 3'd0, 32'h0500);
        check_read("dec_count", 3'd1, 32'h1234);
        check_read("dec_compare", 3'd2, 32'hABCD);
        check_read("dec_capture", 3'd4, 32'h0);

        // Simultaneous read and write returns the old value.
        access(1'b1, 1'b1, 1'b1, {BASE, 3'd2}, 32'h55, q, s);
        check("rw_old", q, 32'hABCD);
        check_read("rw_new", 3'd2, 32'h55);

        // Reset in the middle of counting.
        wr_reg(3'd0, 32'h1);
        idle(3);
        iRST = 1'b1;
        idle(1);
        iRST = 1'b0;
        check_read("midrst_count", 3'd1, 32'h0);
        check_read("midrst_ctrl", 3'd0, 32'h0);
        check_read("midrst_compare", 3'd2, 32'hFFFF_FFFF);

`ifdef TIMER_MMIO_CAPTURE_EN
        begin
            logic [31:0] capv;
            wr_reg(3'd0, 32'h1);
            idle(96);
            cap_sig = 1'b1;
            idle(1);
            cap_sig = 1'b0;
            idle(3);
            access(1'b1, 1'b1, 1'b0, {BASE, 3'd4}, 32'h0, capv, s);
            check("cap_value", capv, 32'd98);
            check("cap_in_range", {31'd0, capv >= 32'd98 && capv <= 32'd100}, 32'd1);
            check_read("cap_flag", 3'd3, 32'h2);
            wr_reg(3'd3, 32'h2);
            check_read("cap_cleared", 3'd3, 32'h0);
            cap_sig = 1'b1;
            idle(1);
            cap_sig = 1'b0;
            idle(1);
            wr_reg(3'd3, 32'h2);
            check_read("cap_collision", 3'd3, 32'h2);
            wr_reg(3'd0, 32'h0);
        end
`endif

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
